// File: rtl/conv_psum_buffer_if.sv
// Handshake/bus bundle between the conv datapath (master) and the partial-sum
// return buffer (slave). Widths must match the buffer's derived AW/PW.
interface conv_psum_buffer_if #(
  parameter int DW = 32,
  parameter int AW = 8,
  parameter int PW = 3
);
  logic          start;
  logic          data_in_valid;
  logic [DW-1:0] data_in;
  logic [DW-1:0] psum_out;
  logic          psum_ready;
  logic [PW-1:0] pass_index;
  logic          ofm_valid;
  logic [DW-1:0] ofm_data;
  logic [AW-1:0] ofm_address;
  logic          layer_done;
  logic          drop_err;

  modport master (
    output start, data_in_valid, data_in,
    input  psum_out, psum_ready, pass_index, ofm_valid, ofm_data,
           ofm_address, layer_done, drop_err
  );

  modport slave (
    input  start, data_in_valid, data_in,
    output psum_out, psum_ready, pass_index, ofm_valid, ofm_data,
           ofm_address, layer_done, drop_err
  );
endinterface

// File: rtl/conv_psum_buffer.sv
// Partial-sum return path for the conv datapath. Each pass stores the
// accumulated word of every filter/pixel entry and replays it on psum_out
// during the next pass; on the final pass the finished words go out on the
// ofm_* bus instead of being stored.
module conv_psum_buffer #(
  parameter int DATA_WIDTH        = 32,
  parameter int OFM_SIZE          = 1,
  parameter int NUMBER_OF_FILTERS = 160,
  parameter int IFM_DEPTH         = 88,
  parameter int NUMBER_OF_UNITS   = 11
) (
  input  logic                clk,
  input  logic                reset,
  conv_psum_buffer_if.slave   bus
);

  localparam int DEPTH      = OFM_SIZE * OFM_SIZE * NUMBER_OF_FILTERS;
  localparam int NUM_PASSES = (IFM_DEPTH + NUMBER_OF_UNITS - 1) / NUMBER_OF_UNITS;
  localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW         = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

  typedef enum logic [1:0] {IDLE, PREFETCH, RUN, DONE} state_t;

  state_t                state;
  logic [AW-1:0]         ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  last_entry;
  logic                  last_pass;
  logic                  wr_en;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;

  // Accept/read/write decode; the write always lands at ptr and the read
  // looks one entry ahead so the two never collide.
  always_comb begin
    accept     = bus.data_in_valid && (state == RUN);
    last_entry = (ptr == AW'(DEPTH - 1));
    last_pass  = (bus.pass_index == PW'(NUM_PASSES - 1));
    wr_en      = accept && !last_pass;
    rd_en      = (state == PREFETCH) || (accept && !last_entry);
    rd_addr    = (state == PREFETCH) ? '0 : ptr + AW'(1);
  end

  // Partial-sum storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ptr] <= bus.data_in;
    end
  end

  // Layer sequencer with registered outputs, including the RAM read register
  // that feeds psum_out (forced to zero on pass 0 so stale data is ignored).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= '0;
      bus.pass_index <= '0;
      bus.psum_out   <= '0;
      bus.psum_ready <= 1'b0;
      bus.ofm_valid  <= 1'b0;
      bus.ofm_data   <= '0;
      bus.ofm_address<= '0;
      bus.layer_done <= 1'b0;
      bus.drop_err   <= 1'b0;
    end else begin
      bus.ofm_valid  <= 1'b0;
      bus.layer_done <= 1'b0;

      if (bus.data_in_valid && (state != RUN)) begin
        bus.drop_err <= 1'b1;
      end

      if (rd_en) begin
        bus.psum_out <= (bus.pass_index == '0) ? '0 : mem[rd_addr];
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= PREFETCH;
            ptr   <= '0;
          end
        end

        PREFETCH: begin
          state          <= RUN;
          bus.psum_ready <= 1'b1;
        end

        RUN: begin
          if (accept) begin
            if (last_pass) begin
              bus.ofm_valid   <= 1'b1;
              bus.ofm_data    <= bus.data_in;
              bus.ofm_address <= ptr;
            end
            if (last_entry) begin
              ptr            <= '0;
              bus.psum_ready <= 1'b0;
              if (last_pass) begin
                state          <= DONE;
                bus.layer_done <= 1'b1;
              end else begin
                state          <= PREFETCH;
                bus.pass_index <= bus.pass_index + PW'(1);
              end
            end else begin
              ptr <= ptr + AW'(1);
            end
          end
        end

        DONE: begin
          state          <= IDLE;
          bus.pass_index <= '0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_psum_buffer.sv
// Self-checking bench: a reduced 4-entry / 2-pass buffer exercised by directed
// layers (gaps, dropped words, stray start, mid-layer reset) against a
// pass-by-pass model, plus a default-size 160-entry / 8-pass buffer.
module tb_conv_psum_buffer;

  localparam int S_DEPTH  = 4;
  localparam int S_PASSES = 2;
  localparam int B_DEPTH  = 160;
  localparam int B_PASSES = 8;

  logic clk;
  logic reset;

  conv_psum_buffer_if #(.DW(32), .AW(2), .PW(1)) sbus ();
  conv_psum_buffer_if #(.DW(32), .AW(8), .PW(3)) bbus ();

  conv_psum_buffer #(
    .DATA_WIDTH(32), .OFM_SIZE(1), .NUMBER_OF_FILTERS(4),
    .IFM_DEPTH(22), .NUMBER_OF_UNITS(11)
  ) dut_small (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus)
  );

  conv_psum_buffer dut_big (
    .clk   (clk),
    .reset (reset),
    .bus   (bbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model of the reduced buffer: words[p][e] is the word accepted for entry e
  // in pass p; pass p>0 must replay words[p-1][e].
  typedef struct { int addr; logic [31:0] data; } ofm_exp_t;
  logic [31:0] words [S_PASSES][S_DEPTH];
  int          m_pass       = 0;
  int          m_entry      = 0;
  bit          model_active = 1'b0;
  logic        m_drop       = 1'b0;
  ofm_exp_t    exp_ofm [$];
  logic [31:0] seen_psum [$];
  logic [31:0] obs_ofm_data [$];
  int          obs_ofm_addr [$];
  int          done_count   = 0;
  int          layers_expected = 0;

  int big_ofm_cnt  = 0;
  int big_done_cnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] exp_psum();
    return (m_pass == 0) ? 32'd0 : words[m_pass-1][m_entry];
  endfunction

  task automatic recordAccept(input logic [31:0] w);
    ofm_exp_t item;
    words[m_pass][m_entry] = w;
    if (m_pass == S_PASSES - 1) begin
      item.addr = m_entry;
      item.data = w;
      exp_ofm.push_back(item);
    end
    m_entry++;
    if (m_entry == S_DEPTH) begin
      m_entry = 0;
      m_pass++;
      if (m_pass == S_PASSES) begin
        m_pass       = 0;
        model_active = 1'b0;
      end
    end
  endtask

  // Called at a negedge: waits (bounded) for psum_ready, presents one word,
  // then idles for 'gap' cycles.
  task automatic applyStimulus(input logic [31:0] w, input int gap);
    int waited = 0;
    while (!sbus.psum_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!sbus.psum_ready) begin
      checkOutput("psum_ready_timeout", 32'(sbus.psum_ready), 32'd1);
      return;
    end
    seen_psum.push_back(sbus.psum_out);
    sbus.data_in       = w;
    sbus.data_in_valid = 1'b1;
    recordAccept(w);
    @(negedge clk);
    sbus.data_in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic startLayer();
    seen_psum.delete();
    obs_ofm_data.delete();
    obs_ofm_addr.delete();
    m_pass       = 0;
    m_entry      = 0;
    model_active = 1'b1;
    sbus.start   = 1'b1;
    @(negedge clk);
    sbus.start   = 1'b0;
  endtask

  task automatic pulseStart();
    sbus.start = 1'b1;
    @(negedge clk);
    sbus.start = 1'b0;
  endtask

  function automatic int gapOf(input int k);
    case (k % 3)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  // Runs a reduced layer; pass 0 words are b0*(e+1), pass 1 words b1*(e+1).
  // stop_after < 8 abandons the layer after that many accepts.
  task automatic runSmallLayer(input int b0, input int b1, input bit gapped,
                               input bit start_mid, input int stop_after);
    int k = 0;
    startLayer();
    for (int p = 0; p < S_PASSES; p++) begin
      for (int e = 0; e < S_DEPTH; e++) begin
        if (k == stop_after) return;
        applyStimulus(32'(((p == 0) ? b0 : b1) * (e + 1)), gapped ? gapOf(k) : 0);
        if (start_mid && k == 1) pulseStart();
        k++;
      end
    end
    repeat (3) @(negedge clk);
    layers_expected++;
    checkOutput("ofm_drained", 32'(exp_ofm.size()), 32'd0);
    checkOutput("layer_done_count", 32'(done_count), 32'(layers_expected));
  endtask

  // Hand-computed sequences for a layer of 1,2,3,4 then 10,20,30,40.
  task automatic checkLayerLiterals();
    logic [31:0] exp_seen [8];
    exp_seen = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
    checkOutput("lit_psum_count", 32'(seen_psum.size()), 32'd8);
    for (int i = 0; i < 8 && i < seen_psum.size(); i++)
      checkOutput("lit_psum", seen_psum[i], exp_seen[i]);
    checkOutput("lit_ofm_count", 32'(obs_ofm_data.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs_ofm_data.size(); i++) begin
      checkOutput("lit_ofm_addr", 32'(obs_ofm_addr[i]), 32'(i));
      checkOutput("lit_ofm_data", obs_ofm_data[i], 32'(10 * (i + 1)));
    end
  endtask

  // Per-cycle compare of the reduced buffer against the model.
  always begin
    ofm_exp_t item;
    @(posedge clk);
    #2;
    if (!reset) begin
      checkOutput("drop_err", 32'(sbus.drop_err), 32'(m_drop));
      if (sbus.psum_ready) begin
        checkOutput("psum_ready_in_layer", 32'(sbus.psum_ready), 32'(model_active));
        if (model_active) begin
          checkOutput("psum_out", sbus.psum_out, exp_psum());
          checkOutput("pass_index", 32'(sbus.pass_index), 32'(m_pass));
        end
      end
      if (sbus.ofm_valid) begin
        obs_ofm_data.push_back(sbus.ofm_data);
        obs_ofm_addr.push_back(int'(sbus.ofm_address));
        checkOutput("ofm_expected", 32'(exp_ofm.size() > 0), 32'd1);
        if (exp_ofm.size() > 0) begin
          item = exp_ofm.pop_front();
          checkOutput("ofm_address", 32'(sbus.ofm_address), 32'(item.addr));
          checkOutput("ofm_data", sbus.ofm_data, item.data);
          checkOutput("layer_done_align", 32'(sbus.layer_done), 32'(item.addr == S_DEPTH - 1));
        end
      end else begin
        checkOutput("layer_done_alone", 32'(sbus.layer_done), 32'd0);
      end
      if (sbus.layer_done) done_count++;
    end
  end

  // Finished-word compare for the default-size buffer: entry i of pass 7 = 7000+i.
  always begin
    @(posedge clk);
    #2;
    if (!reset && bbus.ofm_valid) begin
      checkOutput("big_ofm_address", 32'(bbus.ofm_address), 32'(big_ofm_cnt));
      checkOutput("big_ofm_data", bbus.ofm_data, 32'(7000 + big_ofm_cnt));
      checkOutput("big_layer_done", 32'(bbus.layer_done), 32'(big_ofm_cnt == B_DEPTH - 1));
      big_ofm_cnt++;
    end
    if (!reset && bbus.layer_done) big_done_cnt++;
  end

  task automatic runBigLayer();
    int  bubbles = 0;
    int  waited;
    bit  abort = 1'b0;
    bbus.start = 1'b1;
    @(negedge clk);
    bbus.start = 1'b0;
    for (int p = 0; p < B_PASSES && !abort; p++) begin
      for (int i = 0; i < B_DEPTH && !abort; i++) begin
        waited = 0;
        while (!bbus.psum_ready && waited < 20) begin
          if (p > 0 || i > 0) bubbles++;
          @(negedge clk);
          waited++;
        end
        if (!bbus.psum_ready) begin
          checkOutput("big_ready_timeout", 32'(bbus.psum_ready), 32'd1);
          abort = 1'b1;
        end else begin
          checkOutput("big_psum_out", bbus.psum_out, 32'((p == 0) ? 0 : (p - 1) * 1000 + i));
          checkOutput("big_pass_index", 32'(bbus.pass_index), 32'(p));
          bbus.data_in       = 32'(p * 1000 + i);
          bbus.data_in_valid = 1'b1;
          @(negedge clk);
          bbus.data_in_valid = 1'b0;
        end
      end
    end
    repeat (3) @(negedge clk);
    checkOutput("big_bubbles", 32'(bubbles), 32'd7);
    checkOutput("big_ofm_count", 32'(big_ofm_cnt), 32'd160);
    checkOutput("big_done_count", 32'(big_done_cnt), 32'd1);
    checkOutput("big_drop_err", 32'(bbus.drop_err), 32'd0);
  endtask

  task automatic checkSmallZero(input string tag);
    checkOutput({tag, "_psum_out"},    sbus.psum_out, 32'd0);
    checkOutput({tag, "_psum_ready"},  32'(sbus.psum_ready), 32'd0);
    checkOutput({tag, "_pass_index"},  32'(sbus.pass_index), 32'd0);
    checkOutput({tag, "_ofm_valid"},   32'(sbus.ofm_valid), 32'd0);
    checkOutput({tag, "_ofm_data"},    sbus.ofm_data, 32'd0);
    checkOutput({tag, "_ofm_address"}, 32'(sbus.ofm_address), 32'd0);
    checkOutput({tag, "_layer_done"},  32'(sbus.layer_done), 32'd0);
    checkOutput({tag, "_drop_err"},    32'(sbus.drop_err), 32'd0);
  endtask

  initial begin
    #400000;
    miscompares++;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    reset = 1'b0;
    sbus.start = 1'b0; sbus.data_in_valid = 1'b0; sbus.data_in = '0;
    bbus.start = 1'b0; bbus.data_in_valid = 1'b0; bbus.data_in = '0;
    #1 reset = 1'b1;
    #1;
    checkSmallZero("reset");
    checkOutput("reset_big_psum_out", bbus.psum_out, 32'd0);
    checkOutput("reset_big_pass_index", 32'(bbus.pass_index), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] basic two-pass layer");
    runSmallLayer(1, 10, 1'b0, 1'b0, 8);
    checkLayerLiterals();

    $display("[TB] gapped valids");
    runSmallLayer(1, 10, 1'b1, 1'b0, 8);
    checkLayerLiterals();

    $display("[TB] start pulsed mid-run");
    runSmallLayer(1, 10, 1'b0, 1'b1, 8);
    checkLayerLiterals();

    $display("[TB] word presented in idle");
    sbus.data_in       = 32'hDEAD;
    sbus.data_in_valid = 1'b1;
    m_drop             = 1'b1;
    @(negedge clk);
    sbus.data_in_valid = 1'b0;
    @(negedge clk);
    checkOutput("drop_err_sticky", 32'(sbus.drop_err), 32'd1);
    runSmallLayer(1, 10, 1'b0, 1'b0, 8);
    checkLayerLiterals();

    $display("[TB] reset mid-layer");
    runSmallLayer(1, 10, 1'b0, 1'b0, 6);
    #2 reset = 1'b1;
    #1;
    checkSmallZero("midreset");
    m_pass = 0; m_entry = 0; model_active = 1'b0; m_drop = 1'b0;
    exp_ofm.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    runSmallLayer(5, 50, 1'b1, 1'b0, 8);
    checkOutput("post_reset_first_psum", (seen_psum.size() > 0) ? seen_psum[0] : 32'hFFFF_FFFF, 32'd0);

    $display("[TB] default-size eight-pass layer");
    runBigLayer();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
